// File: rtl/servisia_scan_pkg.sv
// rtl/servisia_scan_pkg.sv - shared types and constants for the servisia scan controller
//
// Purpose: state encoding, default chain/run sizes and a small width helper.
// Ports: none (package).

package servisia_scan_pkg;

  localparam int DEF_CHAIN_LEN = 64;
  localparam int DEF_RUN_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } scan_state_e;

  // The shared counter must hold both CHAIN_LEN-1 and the widest run count.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/servisia_scan_cnt.sv
// rtl/servisia_scan_cnt.sv - loadable down-counter with zero flag
//
// Purpose: cycle counter shared by the SHIFT and RUN phases.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   load_i         load load_val_i (has priority over dec_i)
//   load_val_i     value to load
//   dec_i          decrement request; saturates at zero, never wraps
//   zero_o         counter currently equals zero

module servisia_scan_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/servisia_scan_ctrl.sv
// rtl/servisia_scan_ctrl.sv - scan load/unload controller for the servisia chain
//
// Purpose: accepts a pattern, shifts it into the DUT scan chain while capturing
// the previous chain contents, runs the DUT functionally for a requested number
// of cycles, then presents the captured contents as a response.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   req_valid_i/req_ready_o     request handshake
//   req_data_i                  pattern to load (bit 0 shifted out first)
//   req_run_i                   functional cycles after the load
//   rsp_valid_o/rsp_ready_i     response handshake
//   rsp_data_o                  unloaded chain contents (bit 0 = first received)
//   scan_en_o, scan_d_o         scan enable and serial data toward the DUT chain
//   scan_d_i                    serial data from the DUT chain tail
//   busy_o                      controller not idle

module servisia_scan_ctrl
  import servisia_scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int RUN_W     = DEF_RUN_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [CHAIN_LEN-1:0] req_data_i,
  input  logic [RUN_W-1:0]     req_run_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [CHAIN_LEN-1:0] rsp_data_o,
  output logic                 scan_en_o,
  output logic                 scan_d_o,
  input  logic                 scan_d_i,
  output logic                 busy_o
);

  localparam int CNT_W = max2($clog2(CHAIN_LEN), RUN_W);

  scan_state_e          state_q, state_d;
  logic [CHAIN_LEN-1:0] sreg_q;
  logic [RUN_W-1:0]     run_q;

  logic                 accept;
  logic                 shift;
  logic                 cnt_load;
  logic [CNT_W-1:0]     cnt_load_val;
  logic                 cnt_dec;
  logic                 cnt_zero;

  servisia_scan_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The counter is loaded with N-1 and the phase ends on the edge where it
  // reads zero, so each phase lasts exactly N cycles.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    shift        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          accept       = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(CHAIN_LEN - 1);
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (cnt_zero) begin
          if (run_q != '0) begin
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(run_q) - CNT_W'(1);
            state_d      = ST_RUN;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_zero) begin
          state_d = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The shift register both drives the chain (bit 0 out) and captures the
  // chain tail (into the top bit), so after CHAIN_LEN shifts it holds the old
  // chain contents with the first received bit at position 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q <= '0;
      run_q  <= '0;
    end else if (accept) begin
      sreg_q <= req_data_i;
      run_q  <= req_run_i;
    end else if (shift) begin
      sreg_q <= {scan_d_i, sreg_q[CHAIN_LEN-1:1]};
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign scan_en_o   = (state_q == ST_SHIFT);
  assign scan_d_o    = (state_q == ST_SHIFT) ? sreg_q[0] : 1'b0;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_data_o  = (state_q == ST_RESP) ? sreg_q : '0;

endmodule

// File: tb/tb_servisia_scan_ctrl.sv
// tb/tb_servisia_scan_ctrl.sv - self-checking bench for servisia_scan_ctrl

module tb_servisia_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic [3:0] req_run;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       scan_en;
  logic       scan_d_o;
  logic       scan_d_i;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int idle_err = 0;

  logic [7:0] chain_q;
  logic       preload_en;
  logic [7:0] preload_val;

  servisia_scan_ctrl #(
    .CHAIN_LEN(8),
    .RUN_W    (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .req_run_i   (req_run),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .scan_en_o   (scan_en),
    .scan_d_o    (scan_d_o),
    .scan_d_i    (scan_d_i),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain model: bit 0 feeds the controller, scan_d_o enters at bit 7.
  always @(posedge clk) begin
    if (preload_en) chain_q <= preload_val;
    else if (scan_en) chain_q <= {scan_d_o, chain_q[7:1]};
  end
  assign scan_d_i = chain_q[0];

  always @(negedge clk) begin
    if (rst_n && !scan_en && (scan_d_o !== 1'b0)) idle_err++;
    if (rst_n && rsp_valid && scan_en) idle_err++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] v);
    @(negedge clk);
    preload_val = v;
    preload_en  = 1'b1;
    @(negedge clk);
    preload_en  = 1'b0;
  endtask

  // Starts at a negedge with the controller idle; ends at a negedge in IDLE.
  task automatic do_txn(input logic [7:0] data, input logic [3:0] run, input int ready_delay,
                        output int en_cnt, output int run_low, output int lat,
                        output logic [7:0] dseq, output logic [7:0] rsp);
    int n;
    int ready_err;
    logic [7:0] first;
    en_cnt = 0; run_low = 0; lat = 0; dseq = '0; rsp = '0; ready_err = 0;
    req_valid = 1'b1;
    req_data  = data;
    req_run   = run;
    rsp_ready = 1'b0;
    check("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Keep valid asserted with changed fields: the busy controller must ignore them.
    req_data  = ~data;
    req_run   = run + 4'd5;
    rsp_ready = (ready_delay == 0);
    n = 0;
    while (lat == 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        lat = n;
      end else begin
        if (scan_en) begin
          if (en_cnt < 8) dseq[en_cnt] = scan_d_o;
          en_cnt++;
        end else begin
          run_low++;
        end
        if (req_ready) ready_err++;
      end
    end
    if (lat == 0) begin
      check("rsp_timeout", 32'd0, 32'd1);
    end
    rsp   = rsp_data;
    first = rsp_data;
    for (int k = 0; k < ready_delay; k++) begin
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'(first));
      check("hold_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("busy_ready_low", 32'(ready_err), 32'd0);
    check("post_idle_ready", 32'(req_ready), 32'd1);
    check("post_idle_valid", 32'(rsp_valid), 32'd0);
    check("post_idle_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] preload;
    logic [7:0] data;
    logic [3:0] run;
    logic [7:0] exp_rsp;
    logic [7:0] exp_model;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int en_cnt, run_low, lat, cnt;
    logic [7:0] dseq, rsp;

    vecs[0] = '{8'hA5, 8'h3C, 4'd0,  8'hA5, 8'h3C, 9};
    vecs[1] = '{8'h5A, 8'hC3, 4'd3,  8'h5A, 8'hC3, 12};
    vecs[2] = '{8'hFF, 8'h00, 4'd1,  8'hFF, 8'h00, 10};
    vecs[3] = '{8'h00, 8'hFF, 4'd15, 8'h00, 8'hFF, 24};
    vecs[4] = '{8'h81, 8'h7E, 4'd2,  8'h81, 8'h7E, 11};

    rst_n = 1'b0; req_valid = 1'b0; req_data = '0; req_run = '0; rsp_ready = 1'b0;
    preload_en = 1'b0; preload_val = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_scan_en", 32'(scan_en), 32'd0);
    check("rst_scan_d", 32'(scan_d_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) begin
      preload(vecs[i].preload);
      do_txn(vecs[i].data, vecs[i].run, 0, en_cnt, run_low, lat, dseq, rsp);
      check($sformatf("v%0d_rsp", i), 32'(rsp), 32'(vecs[i].exp_rsp));
      check($sformatf("v%0d_model", i), 32'(chain_q), 32'(vecs[i].exp_model));
      check($sformatf("v%0d_en_cycles", i), 32'(en_cnt), 32'd8);
      check($sformatf("v%0d_scan_d_seq", i), 32'(dseq), 32'(vecs[i].data));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_run_cycles", i), 32'(run_low), 32'(vecs[i].run));
    end

    // Backpressure: response held for 5 cycles, accepted on the 6th.
    preload(8'h11);
    do_txn(8'h96, 4'd0, 5, en_cnt, run_low, lat, dseq, rsp);
    check("bp_rsp", 32'(rsp), 32'h11);
    check("bp_model", 32'(chain_q), 32'h96);

    // Reset after 4 shift edges aborts the operation.
    preload(8'h00);
    req_valid = 1'b1; req_data = 8'hAA; req_run = 4'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_scan_en", 32'(scan_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_scan_en", 32'(scan_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid || busy) cnt++;
    end
    check("abort_no_rsp", 32'(cnt), 32'd0);
    check("abort_model", 32'(chain_q), 32'hA0);
    check("abort_rsp_data", 32'(rsp_data), 32'd0);
    preload(8'h3C);
    do_txn(8'hFF, 4'd0, 0, en_cnt, run_low, lat, dseq, rsp);
    check("after_abort_rsp", 32'(rsp), 32'h3C);
    check("after_abort_model", 32'(chain_q), 32'hFF);
    check("after_abort_latency", 32'(lat), 32'd9);

    // Back-to-back requests.
    preload(8'h5A);
    do_txn(8'h01, 4'd0, 0, en_cnt, run_low, lat, dseq, rsp);
    check("b2b_first_rsp", 32'(rsp), 32'h5A);
    do_txn(8'h80, 4'd0, 0, en_cnt, run_low, lat, dseq, rsp);
    check("b2b_second_rsp", 32'(rsp), 32'h01);
    check("b2b_model", 32'(chain_q), 32'h80);

    check("idle_outputs_quiet", 32'(idle_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
